// File: rtl/dram_reader_pkg.sv
// Shared types and AXI constants for the DRAM read master.
package dram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R
  } rd_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int unsigned bytes_per_beat(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/dram_burst_calc.sv
// Combinational burst sizing: beats left before the next boundary and the
// length of the next burst, clipped to the beats still owed to the requester.
module dram_burst_calc #(
  parameter int unsigned OFFSET_WIDTH   = 12,
  parameter int unsigned SHIFT          = 4,
  parameter int unsigned BOUNDARY_BYTES = 4096
) (
  input  logic [OFFSET_WIDTH-1:0] i_offset,
  input  logic [8:0]              i_remaining,
  output logic [OFFSET_WIDTH:0]   o_btb,
  output logic [8:0]              o_burst
);

  localparam int unsigned CW = (OFFSET_WIDTH + 1 > 9) ? OFFSET_WIDTH + 1 : 9;
  localparam logic [OFFSET_WIDTH:0] BOUND = (OFFSET_WIDTH + 1)'(BOUNDARY_BYTES);

  logic [CW-1:0] w_rem_ext;
  logic [CW-1:0] w_btb_ext;

  always_comb begin
    o_btb     = (BOUND - {1'b0, i_offset}) >> SHIFT;
    w_rem_ext = CW'(i_remaining);
    w_btb_ext = CW'(o_btb);
    // The min never exceeds i_remaining (<= 256), so the narrowing is safe.
    o_burst   = (w_rem_ext < w_btb_ext) ? i_remaining : 9'(o_btb);
  end

endmodule

// File: rtl/dram_read_master.sv
// AXI4 read master: turns one request into serial INCR bursts that never
// cross a boundary, and forwards R beats to the image-data FIFO.
module dram_read_master
  import dram_reader_pkg::*;
#(
  parameter int unsigned DRAM_ADDR_WIDTH = 39,
  parameter int unsigned DRAM_DATA_WIDTH = 128,
  parameter int unsigned BOUNDARY_BYTES  = 4096
) (
  input  logic                       clk_pixel,
  input  logic                       dram_reader_reset,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  input  logic                       dram_read_en,
  output logic                       dram_read_busy,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  output logic                       read_error,
  output logic                       request_dropped,
  output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  localparam int unsigned AW    = DRAM_ADDR_WIDTH;
  localparam int unsigned DW    = DRAM_DATA_WIDTH;
  localparam int unsigned BPB   = bytes_per_beat(DRAM_DATA_WIDTH);
  localparam int unsigned SHIFT = $clog2(BPB);
  localparam int unsigned OFFW  = $clog2(BOUNDARY_BYTES);

  rd_state_t     r_state, w_state_d;
  logic [AW-1:0] r_addr, w_addr_d;
  logic [8:0]    r_remaining, w_remaining_d;
  logic [7:0]    r_beat_cnt, w_beat_cnt_d;
  logic          r_busy, w_busy_d;
  logic          r_arvalid, w_arvalid_d;
  logic [AW-1:0] r_araddr, w_araddr_d;
  logic [7:0]    r_arlen, w_arlen_d;
  logic          r_rready, w_rready_d;
  logic [DW-1:0] r_data, w_data_d;
  logic          r_data_valid, w_data_valid_d;
  logic          r_read_error, w_read_error_d;
  logic          r_dropped, w_dropped_d;

  logic [AW-1:0] w_req_addr;
  logic [8:0]    w_req_remaining;
  logic [AW-1:0] w_calc_addr;
  logic [8:0]    w_calc_remaining;
  logic [OFFW:0] w_btb;
  logic [8:0]    w_burst;
  logic [AW-1:0] w_burst_bytes;
  logic          w_last_beat;
  logic          w_unused_bits;

  assign w_req_addr      = {dram_read_addr[AW-1:SHIFT], {SHIFT{1'b0}}};
  assign w_req_remaining = {1'b0, dram_read_len} + 9'd1;

  // In IDLE the first burst is sized straight from the request so araddr and
  // arlen are already valid in the first AR cycle.
  assign w_calc_addr      = (r_state == IDLE) ? w_req_addr : r_addr;
  assign w_calc_remaining = (r_state == IDLE) ? w_req_remaining : r_remaining;

  dram_burst_calc #(
    .OFFSET_WIDTH  (OFFW),
    .SHIFT         (SHIFT),
    .BOUNDARY_BYTES(BOUNDARY_BYTES)
  ) u_burst_calc (
    .i_offset   (w_calc_addr[OFFW-1:0]),
    .i_remaining(w_calc_remaining),
    .o_btb      (w_btb),
    .o_burst    (w_burst)
  );

  assign w_burst_bytes = (AW'(r_arlen) + AW'(1)) << SHIFT;
  assign w_last_beat   = (r_beat_cnt == r_arlen);
  assign w_unused_bits = ^{dram_read_addr[SHIFT-1:0], w_btb};

  always_comb begin
    w_state_d      = r_state;
    w_addr_d       = r_addr;
    w_remaining_d  = r_remaining;
    w_beat_cnt_d   = r_beat_cnt;
    w_busy_d       = r_busy;
    w_arvalid_d    = r_arvalid;
    w_araddr_d     = r_araddr;
    w_arlen_d      = r_arlen;
    w_rready_d     = r_rready;
    w_data_d       = r_data;
    w_data_valid_d = 1'b0;
    w_read_error_d = r_read_error;
    w_dropped_d    = r_dropped;

    if (dram_read_en && r_busy) begin
      w_dropped_d = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (dram_read_en) begin
          w_addr_d      = w_req_addr;
          w_remaining_d = w_req_remaining;
          w_araddr_d    = w_req_addr;
          w_arlen_d     = 8'(w_burst - 9'd1);
          w_arvalid_d   = 1'b1;
          w_busy_d      = 1'b1;
          w_state_d     = AR;
        end
      end
      AR: begin
        if (r_arvalid && m_axi_arready) begin
          w_arvalid_d   = 1'b0;
          w_beat_cnt_d  = 8'd0;
          w_rready_d    = 1'b1;
          w_addr_d      = r_addr + w_burst_bytes;
          w_remaining_d = r_remaining - (9'(r_arlen) + 9'd1);
          w_state_d     = R;
        end
      end
      R: begin
        if (m_axi_rvalid && r_rready) begin
          w_data_d       = m_axi_rdata;
          w_data_valid_d = 1'b1;
          w_beat_cnt_d   = r_beat_cnt + 8'd1;
          if (m_axi_rresp != AXI_RESP_OKAY || m_axi_rlast != w_last_beat) begin
            w_read_error_d = 1'b1;
          end
          if (w_last_beat) begin
            w_rready_d = 1'b0;
            if (r_remaining != 9'd0) begin
              w_araddr_d  = r_addr;
              w_arlen_d   = 8'(w_burst - 9'd1);
              w_arvalid_d = 1'b1;
              w_state_d   = AR;
            end else begin
              w_busy_d  = 1'b0;
              w_state_d = IDLE;
            end
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (dram_reader_reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_beat_cnt   <= '0;
      r_busy       <= 1'b0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_rready     <= 1'b0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_read_error <= 1'b0;
      r_dropped    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_addr       <= w_addr_d;
      r_remaining  <= w_remaining_d;
      r_beat_cnt   <= w_beat_cnt_d;
      r_busy       <= w_busy_d;
      r_arvalid    <= w_arvalid_d;
      r_araddr     <= w_araddr_d;
      r_arlen      <= w_arlen_d;
      r_rready     <= w_rready_d;
      r_data       <= w_data_d;
      r_data_valid <= w_data_valid_d;
      r_read_error <= w_read_error_d;
      r_dropped    <= w_dropped_d;
    end
  end

  assign dram_read_busy       = r_busy;
  assign dram_read_data       = r_data;
  assign dram_read_data_valid = r_data_valid;
  assign read_error           = r_read_error;
  assign request_dropped      = r_dropped;
  assign m_axi_araddr         = r_araddr;
  assign m_axi_arlen          = r_arlen;
  assign m_axi_arsize         = 3'(SHIFT);
  assign m_axi_arburst        = AXI_BURST_INCR;
  assign m_axi_arvalid        = r_arvalid;
  assign m_axi_rready         = r_rready;

endmodule
